// File: rtl/wop_fetch_buf.sv
// Fetch buffer: circular FIFO of 64-bit fetch words that presents narrow (64b) or wide (128b) bundles to the decoder.
// Optional bundle statistics counters are built when WOP_FBUF_STATS_EN is defined.
module wop_fetch_buf #(
    parameter int unsigned FBUF_DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [63:0]  fetchData,
    input  logic         fetchValid,
    output logic         fetchReady,
    input  logic         flush,
    output logic [127:0] istrWord,
    output logic         istrValid,
    input  logic         istrReady,
    output logic [15:0]  statBundles,
    output logic [15:0]  statWide
);

    localparam int unsigned PTR_W = (FBUF_DEPTH > 1) ? $clog2(FBUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FBUF_DEPTH + 1);

    logic [63:0]      entry [FBUF_DEPTH];
    logic [PTR_W-1:0] rd;
    logic [PTR_W-1:0] wr;
    logic [PTR_W-1:0] rd_plus1;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] pop_cnt;
    logic             has_one;
    logic             has_two;
    logic             wide;
    logic             push;
    logic             pop;

    // Bundle view: lower half from rd, upper half from rd+1 (wraps because depth is a power of two)
    assign rd_plus1          = rd + PTR_W'(1);
    assign has_one           = count >= CNT_W'(1);
    assign has_two           = count >= CNT_W'(2);
    assign istrWord[63:0]    = has_one ? entry[rd] : 64'd0;
    assign istrWord[127:64]  = has_two ? entry[rd_plus1] : 64'd0;
    assign wide              = istrWord[63];
    assign istrValid         = !flush && (wide ? has_two : has_one);

    assign fetchReady = count < CNT_W'(FBUF_DEPTH);
    assign push       = fetchValid && fetchReady && !flush;
    assign pop        = istrValid && istrReady;
    assign pop_cnt    = pop ? (wide ? CNT_W'(2) : CNT_W'(1)) : CNT_W'(0);

    // Pointer and occupancy state; flush discards everything including the same-cycle push
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wr <= wr + PTR_W'(1);
            end
            rd    <= rd + PTR_W'(pop_cnt);
            count <= count + CNT_W'(push) - pop_cnt;
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clock) begin
        if (reset && push) begin
            entry[wr] <= fetchData;
        end
    end

`ifdef WOP_FBUF_STATS_EN
    logic [15:0] stat_bundles;
    logic [15:0] stat_wide;

    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_bundles <= '0;
            stat_wide    <= '0;
        end else if (pop) begin
            stat_bundles <= stat_bundles + 16'd1;
            if (wide) begin
                stat_wide <= stat_wide + 16'd1;
            end
        end
    end

    assign statBundles = stat_bundles;
    assign statWide    = stat_wide;
`else
    assign statBundles = 16'd0;
    assign statWide    = 16'd0;
`endif

endmodule

// File: tb/tb_wop_fetch_buf.sv
// Directed table-driven bench for wop_fetch_buf (FBUF_DEPTH = 4); stats expectations follow WOP_FBUF_STATS_EN.
module tb_wop_fetch_buf;

    logic         clock = 1'b0;
    logic         reset;
    logic [63:0]  fetchData;
    logic         fetchValid;
    logic         fetchReady;
    logic         flush;
    logic [127:0] istrWord;
    logic         istrValid;
    logic         istrReady;
    logic [15:0]  statBundles;
    logic [15:0]  statWide;

    int checks   = 0;
    int failures = 0;

    wop_fetch_buf #(.FBUF_DEPTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .fetchData   (fetchData),
        .fetchValid  (fetchValid),
        .fetchReady  (fetchReady),
        .flush       (flush),
        .istrWord    (istrWord),
        .istrValid   (istrValid),
        .istrReady   (istrReady),
        .statBundles (statBundles),
        .statWide    (statWide)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         rst;
        logic         fv;
        logic [63:0]  fd;
        logic         fl;
        logic         ir;
        logic         e_frdy;
        logic         e_ival;
        logic [127:0] e_word;
        logic [15:0]  e_bund;
        logic [15:0]  e_wide;
    } vec_t;

    vec_t vecs[$];

    localparam logic [63:0] Z  = 64'h0;
    localparam logic [63:0] A  = 64'h0000_0000_1234_5678;
    localparam logic [63:0] W1 = 64'h8000_0000_0000_0001;
    localparam logic [63:0] W2 = 64'h0000_0000_0000_0002;
    localparam logic [63:0] W3 = 64'h8000_0000_0000_00A3;
    localparam logic [63:0] D4 = 64'h0000_0000_0000_00B4;
    localparam logic [63:0] N1 = 64'h11;
    localparam logic [63:0] N2 = 64'h22;
    localparam logic [63:0] N3 = 64'h33;
    localparam logic [63:0] N4 = 64'h44;
    localparam logic [63:0] N5 = 64'h55;
    localparam logic [63:0] F1 = 64'h101;
    localparam logic [63:0] F2 = 64'h102;
    localparam logic [63:0] F3 = 64'h103;
    localparam logic [63:0] FX = 64'h1_DEAD;
    localparam logic [63:0] G1 = 64'h201;
    localparam logic [63:0] M1 = 64'h301;
    localparam logic [63:0] M2 = 64'h302;
    localparam logic [63:0] H1 = 64'h401;
    localparam logic [63:0] H2 = 64'h402;

    function automatic logic [15:0] st(input int v);
`ifdef WOP_FBUF_STATS_EN
        return 16'(v);
`else
        return 16'(v * 0);
`endif
    endfunction

    task automatic add(input logic rst, input logic fv, input logic [63:0] fd, input logic fl,
                       input logic ir, input logic frdy, input logic ival,
                       input logic [63:0] hi, input logic [63:0] lo, input int b, input int w);
        vec_t v;
        v.rst = rst; v.fv = fv; v.fd = fd; v.fl = fl; v.ir = ir;
        v.e_frdy = frdy; v.e_ival = ival; v.e_word = {hi, lo};
        v.e_bund = st(b); v.e_wide = st(w);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fv, input logic [63:0] fd, input logic fl, input logic ir);
        reset = rst; fetchValid = fv; fetchData = fd; flush = fl; istrReady = ir;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, Z, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk("reset_fetchReady", -1, 128'(fetchReady), 128'(1'b1));
        chk("reset_istrValid", -1, 128'(istrValid), 128'(1'b0));
        chk("reset_istrWord", -1, istrWord, 128'd0);
        chk("reset_statBundles", -1, 128'(statBundles), 128'd0);
        next_cycle();

        // narrow bundle
        add(1,1,A ,0,1, 1,0,Z ,Z ,0,0);
        add(1,0,Z ,0,1, 1,1,Z ,A ,0,0);
        add(1,0,Z ,0,1, 1,0,Z ,Z ,1,0);
        // wide bundle waiting for its second half
        add(1,1,W1,0,1, 1,0,Z ,Z ,1,0);
        add(1,0,Z ,0,1, 1,0,Z ,W1,1,0);
        add(1,1,W2,0,1, 1,0,Z ,W1,1,0);
        add(1,0,Z ,0,1, 1,1,W2,W1,1,0);
        // wide bundle straddling the wrap (rd = 3)
        add(1,1,W3,0,1, 1,0,Z ,Z ,2,1);
        add(1,1,D4,0,1, 1,0,Z ,W3,2,1);
        add(1,0,Z ,0,1, 1,1,D4,W3,2,1);
        // fill under stall, fifth word refused, drain in order
        add(1,1,N1,0,0, 1,0,Z ,Z ,3,2);
        add(1,1,N2,0,0, 1,1,Z ,N1,3,2);
        add(1,1,N3,0,0, 1,1,N2,N1,3,2);
        add(1,1,N4,0,0, 1,1,N2,N1,3,2);
        add(1,1,N5,0,0, 0,1,N2,N1,3,2);
        add(1,0,Z ,0,1, 0,1,N2,N1,3,2);
        add(1,0,Z ,0,1, 1,1,N3,N2,4,2);
        add(1,0,Z ,0,1, 1,1,N4,N3,5,2);
        add(1,0,Z ,0,1, 1,1,Z ,N4,6,2);
        add(1,0,Z ,0,1, 1,0,Z ,Z ,7,2);
        // flush at count 3 with a same-cycle fetch
        add(1,1,F1,0,0, 1,0,Z ,Z ,7,2);
        add(1,1,F2,0,0, 1,1,Z ,F1,7,2);
        add(1,1,F3,0,0, 1,1,F2,F1,7,2);
        add(1,1,FX,1,1, 1,0,F2,F1,7,2);
        add(1,0,Z ,0,1, 1,0,Z ,Z ,7,2);
        add(1,1,G1,0,1, 1,0,Z ,Z ,7,2);
        add(1,0,Z ,0,1, 1,1,Z ,G1,7,2);
        // reset mid-stream
        add(1,1,M1,0,0, 1,0,Z ,Z ,8,2);
        add(1,1,M2,0,0, 1,1,Z ,M1,8,2);
        add(0,0,Z ,0,0, 1,1,M2,M1,8,2);
        add(1,0,Z ,0,1, 1,0,Z ,Z ,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].fv, vecs[i].fd, vecs[i].fl, vecs[i].ir);
            @(negedge clock);
            chk("fetchReady", i, 128'(fetchReady), 128'(vecs[i].e_frdy));
            chk("istrValid", i, 128'(istrValid), 128'(vecs[i].e_ival));
            chk("istrWord", i, istrWord, vecs[i].e_word);
            chk("statBundles", i, 128'(statBundles), 128'(vecs[i].e_bund));
            chk("statWide", i, 128'(statWide), 128'(vecs[i].e_wide));
            next_cycle();
        end

        // simultaneous push and pop keeps occupancy at one
        drive(1'b1, 1'b1, H1, 1'b0, 1'b0);
        @(negedge clock);
        chk("pp_idle_valid", 100, 128'(istrValid), 128'(1'b0));
        next_cycle();
        drive(1'b1, 1'b1, H2, 1'b0, 1'b1);
        @(negedge clock);
        chk("pp_first_valid", 101, 128'(istrValid), 128'(1'b1));
        chk("pp_first_word", 101, istrWord, {Z, H1});
        next_cycle();
        drive(1'b1, 1'b0, Z, 1'b0, 1'b1);
        @(negedge clock);
        chk("pp_second_valid", 102, 128'(istrValid), 128'(1'b1));
        chk("pp_second_word", 102, istrWord, {Z, H2});
        chk("pp_stat_bundles", 102, 128'(statBundles), 128'(st(1)));
        next_cycle();
        drive(1'b1, 1'b0, Z, 1'b0, 1'b1);
        @(negedge clock);
        chk("pp_empty_valid", 103, 128'(istrValid), 128'(1'b0));
        chk("pp_empty_word", 103, istrWord, 128'd0);
        chk("pp_stat_bundles_end", 103, 128'(statBundles), 128'(st(2)));
        chk("pp_stat_wide_end", 103, 128'(statWide), 128'(st(0)));
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
